// File: rtl/gate_logic_unit_if.sv
// Operand/result bus for gate_logic_unit; master drives operands, slave returns registered results.
// The parity wire exists only when GATE_LOGIC_PARITY_EN is defined.
interface gate_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] nand_out;
    logic [WIDTH-1:0] or_out;
    logic [WIDTH-1:0] xor_out;
    logic [WIDTH-1:0] not_out;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef GATE_LOGIC_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, a, b, op,
        input  out_valid, and_out, nand_out, or_out, xor_out, not_out, result, zero, parity
    );
    modport slave (
        input  in_valid, a, b, op,
        output out_valid, and_out, nand_out, or_out, xor_out, not_out, result, zero, parity
    );
`else
    modport master (
        output in_valid, a, b, op,
        input  out_valid, and_out, nand_out, or_out, xor_out, not_out, result, zero
    );
    modport slave (
        input  in_valid, a, b, op,
        output out_valid, and_out, nand_out, or_out, xor_out, not_out, result, zero
    );
`endif
endinterface

// File: rtl/gate_logic_unit.sv
// Bitwise logic slice: AND/NAND/OR/XOR/NOT of a plus op-selected result and zero flag (GATE_LOGIC_PARITY_EN adds parity).
// Latency: 1 cycle from accepted input to out_valid with registered results.
// Backpressure: none; every in_valid beat is accepted, data holds when in_valid=0.
module gate_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_logic_unit_if.slave   bus
);

    typedef struct packed {
        logic [WIDTH-1:0] and_v;
        logic [WIDTH-1:0] nand_v;
        logic [WIDTH-1:0] or_v;
        logic [WIDTH-1:0] xor_v;
        logic [WIDTH-1:0] not_v;
        logic [WIDTH-1:0] res_v;
        logic             zero;
    } gate_res_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NOT  = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } gate_op_e;

    gate_res_t        res_d, res_q;
    logic             vld_d, vld_q;
    logic [WIDTH-1:0] sel_v;
    gate_op_e         op_sel;

    assign op_sel = gate_op_e'(bus.op);

    // All eight codes decode to a defined function, so op never injects X into result.
    always_comb begin
        sel_v = bus.a;
        case (op_sel)
            OP_AND:  sel_v = bus.a & bus.b;
            OP_NAND: sel_v = ~(bus.a & bus.b);
            OP_OR:   sel_v = bus.a | bus.b;
            OP_XOR:  sel_v = bus.a ^ bus.b;
            OP_NOT:  sel_v = ~bus.a;
            OP_NOR:  sel_v = ~(bus.a | bus.b);
            OP_XNOR: sel_v = ~(bus.a ^ bus.b);
            OP_PASS: sel_v = bus.a;
            default: sel_v = bus.a;
        endcase
    end

    always_comb begin
        res_d = res_q;
        vld_d = bus.in_valid;
        if (bus.in_valid) begin
            res_d.and_v  = bus.a & bus.b;
            res_d.nand_v = ~(bus.a & bus.b);
            res_d.or_v   = bus.a | bus.b;
            res_d.xor_v  = bus.a ^ bus.b;
            res_d.not_v  = ~bus.a;
            res_d.res_v  = sel_v;
            res_d.zero   = (sel_v == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

`ifdef GATE_LOGIC_PARITY_EN
    logic parity_d, parity_q;

    always_comb begin
        parity_d = parity_q;
        if (bus.in_valid) begin
            parity_d = ^sel_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity = parity_q;
`endif

    assign bus.out_valid = vld_q;
    assign bus.and_out   = res_q.and_v;
    assign bus.nand_out  = res_q.nand_v;
    assign bus.or_out    = res_q.or_v;
    assign bus.xor_out   = res_q.xor_v;
    assign bus.not_out   = res_q.not_v;
    assign bus.result    = res_q.res_v;
    assign bus.zero      = res_q.zero;

endmodule

// File: tb/tb_gate_logic_unit.sv
// Bench for gate_logic_unit: an 8-bit instance checked against a truth-table model plus a 1-bit instance.
module tb_gate_logic_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    gate_logic_unit_if #(.WIDTH(8)) bus8 ();
    gate_logic_unit_if #(.WIDTH(1)) bus1 ();

    gate_logic_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    gate_logic_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-op truth table indexed by {a[i], b[i]}: the spec's op list written as 2-input gate tables.
    localparam logic [3:0] TT [0:7] = '{4'b1000, 4'b0111, 4'b1110, 4'b0110,
                                        4'b0011, 4'b0001, 4'b1001, 4'b1100};

    function automatic logic [7:0] lut(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] r;
        tt = TT[op];
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // Reference: last accepted transaction, cleared by reset.
    logic       exp_vld;
    logic [7:0] exp_and, exp_nand, exp_or, exp_xor, exp_not, exp_res;
    logic       exp_zero, exp_par;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_vld <= 1'b0; exp_and <= '0; exp_nand <= '0; exp_or <= '0;
            exp_xor <= '0;   exp_not <= '0; exp_res <= '0;  exp_zero <= 1'b0; exp_par <= 1'b0;
        end else begin
            exp_vld <= bus8.in_valid;
            if (bus8.in_valid) begin
                exp_and  <= lut(3'd0, bus8.a, bus8.b);
                exp_nand <= lut(3'd1, bus8.a, bus8.b);
                exp_or   <= lut(3'd2, bus8.a, bus8.b);
                exp_xor  <= lut(3'd3, bus8.a, bus8.b);
                exp_not  <= lut(3'd4, bus8.a, bus8.b);
                exp_res  <= lut(bus8.op, bus8.a, bus8.b);
                exp_zero <= (lut(bus8.op, bus8.a, bus8.b) == 8'h00);
                exp_par  <= ^lut(bus8.op, bus8.a, bus8.b);
            end
        end
    end

    logic [49:0] act8, exp8;
    assign act8 = {bus8.out_valid, bus8.and_out, bus8.nand_out, bus8.or_out, bus8.xor_out,
                   bus8.not_out, bus8.result, bus8.zero};
    assign exp8 = {exp_vld, exp_and, exp_nand, exp_or, exp_xor, exp_not, exp_res, exp_zero};

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        @(negedge clk);
        bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.op = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.op = 3'd1;
        bus1.in_valid = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b1;  bus1.op = 3'd1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (act8 !== 50'd0) begin
            n_fail++; $display("FAIL reset_async_w8 got=%h want=0", act8);
        end
        n_tests++;
        if ({bus1.out_valid, bus1.and_out, bus1.nand_out, bus1.or_out, bus1.xor_out,
             bus1.not_out, bus1.result, bus1.zero} !== 8'd0) begin
            n_fail++; $display("FAIL reset_async_w1 got nand=%b not=%b vld=%b want 0",
                               bus1.nand_out, bus1.not_out, bus1.out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (act8 !== 50'd0) begin
            n_fail++; $display("FAIL reset_held got=%h want=0", act8);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0; bus1.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_truth_w1();
        logic       ta [0:3];
        logic       tb [0:3];
        logic [4:0] te [0:3];
        logic [4:0] got;
        ta = '{1'b0, 1'b1, 1'b0, 1'b1};
        tb = '{1'b0, 1'b0, 1'b1, 1'b1};
        te = '{5'b01001, 5'b01110, 5'b01111, 5'b10100};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1; bus1.a = ta[i]; bus1.b = tb[i]; bus1.op = 3'd0;
            @(posedge clk);
            #1;
            got = {bus1.and_out, bus1.nand_out, bus1.or_out, bus1.xor_out, bus1.not_out};
            n_tests++;
            if (got !== te[i] || bus1.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL truth_w1[%0d] got=%b vld=%b want=%b vld=1", i, got, bus1.out_valid, te[i]);
            end
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_bitwise();
        drive8(1'b1, 8'hA5, 8'h3C, 3'd0);
        n_tests++;
        if ({bus8.and_out, bus8.nand_out, bus8.or_out, bus8.xor_out, bus8.not_out} !== 40'h24_DB_BD_99_5A) begin
            n_fail++; $display("FAIL bitwise got=%h_%h_%h_%h_%h want=24_db_bd_99_5a",
                               bus8.and_out, bus8.nand_out, bus8.or_out, bus8.xor_out, bus8.not_out);
        end
        n_tests++;
        if (bus8.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bitwise_vld got=%b want=1", bus8.out_valid);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] want [0:7];
        want = '{8'h24, 8'hDB, 8'hBD, 8'h99, 8'h5A, 8'h42, 8'h66, 8'hA5};
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 8'hA5, 8'h3C, 3'(i));
            n_tests++;
            if (bus8.result !== want[i] || bus8.zero !== 1'b0 || bus8.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL op_sweep[%0d] got=%h zero=%b vld=%b want=%h zero=0 vld=1",
                                   i, bus8.result, bus8.zero, bus8.out_valid, want[i]);
            end
        end
        drive8(1'b1, 8'h0F, 8'hF0, 3'd0);
        n_tests++;
        if (bus8.result !== 8'h00 || bus8.zero !== 1'b1) begin
            n_fail++; $display("FAIL op_zero got=%h zero=%b want=00 zero=1", bus8.result, bus8.zero);
        end
    endtask

    task automatic test_hold();
        drive8(1'b1, 8'h12, 8'h34, 3'd3);
        for (int i = 0; i < 3; i++) begin
            drive8(1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
            n_tests++;
            if (act8 !== {1'b0, 8'h10, 8'hEF, 8'h36, 8'h26, 8'hED, 8'h26, 1'b0}) begin
                n_fail++; $display("FAIL hold[%0d] got=%h want=%h", i, act8,
                                   {1'b0, 8'h10, 8'hEF, 8'h36, 8'h26, 8'hED, 8'h26, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            drive8(($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 3'($urandom));
            n_tests++;
            if (act8 !== exp8) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL random[%0d] got=%h want=%h", i, act8, exp8);
            end
`ifdef GATE_LOGIC_PARITY_EN
            n_tests++;
            if (bus8.parity !== exp_par) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL random_parity[%0d] got=%b want=%b", i, bus8.parity, exp_par);
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 3; i++) drive8(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (act8 !== 50'd0) begin
            n_fail++; $display("FAIL midreset_clear got=%h want=0", act8);
        end
`ifdef GATE_LOGIC_PARITY_EN
        n_tests++;
        if (bus8.parity !== 1'b0) begin
            n_fail++; $display("FAIL midreset_parity got=%b want=0", bus8.parity);
        end
`endif
        #1 rst_n = 1'b1;
        drive8(1'b1, 8'hA5, 8'h3C, 3'd1);
        n_tests++;
        if (bus8.result !== 8'hDB || bus8.nand_out !== 8'hDB || bus8.out_valid !== 1'b1 || bus8.zero !== 1'b0) begin
            n_fail++; $display("FAIL midreset_resume got=%h nand=%h vld=%b want=db nand=db vld=1",
                               bus8.result, bus8.nand_out, bus8.out_valid);
        end
`ifdef GATE_LOGIC_PARITY_EN
        n_tests++;
        if (bus8.parity !== 1'b0) begin
            n_fail++; $display("FAIL midreset_resume_parity got=%b want=0", bus8.parity);
        end
`endif
        drive8(1'b0, 8'h00, 8'h00, 3'd0);
        n_tests++;
        if (act8 !== exp8) begin
            n_fail++; $display("FAIL midreset_idle got=%h want=%h", act8, exp8);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_truth_w1();
        test_bitwise();
        test_op_sweep();
        test_hold();
        test_back_to_back();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_logic_unit.md
Name: gate_logic_unit

Overview:
Registered bitwise logic unit that computes AND, NAND, OR, XOR and NOT (of operand a) over two WIDTH-bit operands in parallel, plus one op-selected result with a zero flag. It is the logic-slice leaf of the ALU datapath and sits beside the adder. Results appear one clock after an accepted input, with a valid strobe.

Parameters:
WIDTH, 8, operand and result bit width (legal range 1..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operands/op valid this cycle; accepted unconditionally
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  result select (encoding below)
out_valid  output  1  registered outputs updated by the previous cycle's accepted input
and_out  output  WIDTH  a & b
nand_out  output  WIDTH  ~(a & b)
or_out  output  WIDTH  a | b
xor_out  output  WIDTH  a ^ b
not_out  output  WIDTH  ~a
result  output  WIDTH  op-selected function
zero  output  1  result == 0

Behaviour:
- Reset is asynchronous and active-low; clock domain is clk only.
- While rst_n=0: out_valid=0 and every data output and zero are 0, including nand_out and not_out (registered values, not gate evaluations).
- Latency is 1 cycle: on the rising edge where in_valid=1, all five gate outputs, result and zero load from the current a, b, op; out_valid=1 on the following cycle.
- On an edge with in_valid=0: out_valid goes to 0; all data outputs and zero hold their last values.
- Back-to-back: in_valid held high gives one result per cycle; no stall or backpressure.
- Gate outputs are strictly bitwise; bit i of each output depends only on a[i], b[i].
- op encoding: 0 AND, 1 NAND, 2 OR, 3 XOR, 4 NOT a, 5 NOR ~(a|b), 6 XNOR ~(a^b), 7 pass a.
- zero=1 exactly when the registered result is all zeros; computed from the same inputs in the same cycle as result.
- No X propagation from op: every 3-bit code is defined.
- Reset asserted mid-stream clears everything immediately, regardless of clock; the first edge after release with in_valid=1 behaves as a normal accept.

Optional Feature:
Macro GATE_LOGIC_PARITY_EN. When defined: extra output port parity (1 bit), registered alongside result, equal to the XOR-reduction of result; reset value 0; holds when in_valid=0. When undefined: the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 with a=FF, b=FF, in_valid=1 -> all outputs 0, out_valid=0, asynchronously, before any clock edge.
- Truth table, WIDTH=1: apply (a,b)=(0,0),(1,0),(0,1),(1,1), one per cycle, in_valid=1 -> one cycle later and/nand/or/xor/not = 0/1/0/0/1, 0/1/1/1/0, 0/1/1/1/1, 1/0/1/0/0; out_valid=1 each cycle.
- WIDTH=8 bitwise: a=0xA5, b=0x3C -> and 0x24, nand 0xDB, or 0xBD, xor 0x99, not 0x5A.
- op sweep, a=0xA5, b=0x3C, op=0..7 back-to-back -> result 0x24, 0xDB, 0xBD, 0x99, 0x5A, 0x42, 0x66, 0xA5; zero=0 throughout. Then a=0x0F, b=0xF0, op=0 -> result 0x00, zero=1.
- Hold: accept a=0x12, b=0x34, then in_valid=0 for 3 cycles with a, b changing -> out_valid=0 on those cycles, data outputs stay at the 0x12/0x34 results.
- Mid-stream reset: pulse rst_n low between clock edges during back-to-back traffic -> outputs clear immediately; the next accepted input yields a correct result one cycle later. With GATE_LOGIC_PARITY_EN defined, result 0xDB -> parity 0.
